// File: rtl/if_fetch_stage.sv
`timescale 1ns/1ps
// RV32I IF stage: owns the PC, issues in-order imem fetches, buffers words in a prefetch FIFO, drives IF/ID.
// Build option IF_MISALIGN_TRAP_EN: a misaligned redirect delivers one trap bubble and halts fetch.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        if_id_misalign
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic          run_q, run_d, halt_q, halt_d;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic          ifid_valid_q, ifid_valid_d;
  logic [31:0]   ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d, ifid_pc4_q, ifid_pc4_d;
  logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];

  logic [31:0]   tgt_pc;
  logic          misalign_redir;
  logic [CW:0]   occ;
  logic          fire, rsp_take, load, pop, bypass, push;

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign tgt_pc         = redirect_pc;
  assign misalign_redir = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign if_id_misalign = misalign_q;
`else
  assign tgt_pc         = redirect_pc & 32'hFFFF_FFFC;
  assign misalign_redir = 1'b0;
`endif

  // Slots already spoken for: buffered words plus requests whose data is still due.
  assign occ            = {1'b0, cnt_q} + {1'b0, outst_q};
  assign imem_req_valid = run_q && !halt_q && !redirect_valid && (occ < (CW+1)'(FIFO_DEPTH));
  assign imem_addr      = pc_q;
  assign fire           = imem_req_valid && imem_req_ready;

  assign rsp_take = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign load     = !redirect_valid && !stall;
  assign pop      = load && (cnt_q != '0);
  assign bypass   = load && (cnt_q == '0) && rsp_take;
  assign push     = rsp_take && !bypass;

  always_comb begin
    pc_d         = pc_q;
    rsp_pc_d     = rsp_pc_q;
    run_d        = 1'b1;
    halt_d       = halt_q;
    outst_d      = outst_q + CW'(fire) - CW'(imem_rsp_valid);
    drop_d       = drop_q;
    cnt_d        = cnt_q + CW'(push) - CW'(pop);
    rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
`ifdef IF_MISALIGN_TRAP_EN
    misalign_d   = misalign_q;
`endif
    if (fire)                             pc_d     = pc_q + 32'd4;
    if (rsp_take)                         rsp_pc_d = rsp_pc_q + 32'd4;
    if (imem_rsp_valid && drop_q != '0)   drop_d   = drop_q - CW'(1);

    if (pop) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = fifo_pc_q[rd_ptr_q];
      ifid_instr_d = fifo_instr_q[rd_ptr_q];
      ifid_pc4_d   = fifo_pc_q[rd_ptr_q] + 32'd4;
    end else if (bypass) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = rsp_pc_q;
      ifid_instr_d = imem_rsp_data;
      ifid_pc4_d   = rsp_pc_q + 32'd4;
    end else if (load) begin
      ifid_valid_d = 1'b0;
    end
`ifdef IF_MISALIGN_TRAP_EN
    if (load) misalign_d = 1'b0;
`endif

    // Everything still in flight is stale; a response landing this cycle is one of them.
    if (redirect_valid) begin
      pc_d         = tgt_pc;
      rsp_pc_d     = tgt_pc;
      halt_d       = misalign_redir;
      drop_d       = outst_q - CW'(imem_rsp_valid);
      cnt_d        = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      ifid_valid_d = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
      misalign_d   = misalign_redir;
`endif
      if (misalign_redir) begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = redirect_pc;
        ifid_instr_d = NOP;
        ifid_pc4_d   = redirect_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      rsp_pc_q     <= RESET_PC;
      run_q        <= 1'b0;
      halt_q       <= 1'b0;
      outst_q      <= '0;
      drop_q       <= '0;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
`ifdef IF_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      pc_q         <= pc_d;
      rsp_pc_q     <= rsp_pc_d;
      run_q        <= run_d;
      halt_q       <= halt_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
`ifdef IF_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  // The issue rule reserves a slot per request, so these can only fire on a broken memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(push && !pop && cnt_q == CW'(FIFO_DEPTH)));
      assert (!(imem_rsp_valid && outst_q == '0));
    end
  end

  assign if_id_valid    = ifid_valid_q;
  assign if_id_pc       = ifid_pc_q;
  assign if_id_instr    = ifid_instr_q;
  assign if_id_pc_plus4 = ifid_pc4_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
`timescale 1ns/1ps
// Randomised bench for if_fetch_stage against a queue-level model of fetch, buffering and IF/ID delivery.
module tb_if_fetch_stage;
  localparam int          D   = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_instr, if_id_pc_plus4;
`ifdef IF_MISALIGN_TRAP_EN
  logic        if_id_misalign;
`endif

  if_fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4)
`ifdef IF_MISALIGN_TRAP_EN
    , .if_id_misalign(if_id_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        pend[$];   // requests accepted by memory, oldest first
  ent_t        fq[$];     // fetched words not yet handed to decode
  logic [31:0] pc_exp;
  bit          run, halted;
  bit          m_v, m_mis;
  logic [31:0] m_pc, m_instr, m_p4;
  int          n_cmp = 0, n_err = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    pend.delete(); fq.delete();
    pc_exp = RPC; run = 0; halted = 0;
    m_v = 0; m_mis = 0; m_pc = '0; m_instr = '0; m_p4 = '0;
    #1;
    chk("rst_req_vld", 32'(imem_req_valid), 0);
    chk("rst_ifid_vld", 32'(if_id_valid), 0);
    chk("rst_ifid_pc", if_id_pc, 0);
    chk("rst_ifid_instr", if_id_instr, 0);
    chk("rst_ifid_pc4", if_id_pc_plus4, 0);
`ifdef IF_MISALIGN_TRAP_EN
    chk("rst_misalign", 32'(if_id_misalign), 0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // One clock: drive inputs, check the request side, advance the model, check IF/ID.
  // mode: 0 random memory response, 1 respond whenever possible, 2 never respond.
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt, input logic rdy,
                      input int mode);
    req_t h;
    ent_t e;
    logic rv;
    logic [31:0] a;
    bit exp_rv;
    stall = st; redirect_valid = rd; redirect_pc = tgt; imem_req_ready = rdy;
    imem_rsp_valid = (pend.size() > 0) && (mode == 1 || (mode == 0 && $urandom_range(3) != 0));
    imem_rsp_data  = imem_rsp_valid ? memf(pend[0].addr) : $urandom;
    @(negedge clk);
    rv = imem_req_valid; a = imem_addr;
    exp_rv = run && !rd && !halted && (pend.size() + fq.size() < D);
    chk("req_vld", 32'(rv), 32'(exp_rv));
    if (rv && exp_rv) chk("req_addr", a, pc_exp);
    chk("inflight_le_depth", 32'(pend.size() <= D), 1);
    run = 1;
    if (imem_rsp_valid) begin
      h = pend.pop_front();
      if (!rd && !h.stale) fq.push_back('{h.addr, memf(h.addr)});
    end
    if (rd) begin
      foreach (pend[i]) pend[i].stale = 1;
      fq.delete();
      m_v = 0; m_mis = 0;
`ifdef IF_MISALIGN_TRAP_EN
      pc_exp = tgt;
      halted = (tgt[1:0] != 2'b00);
      if (halted) begin
        m_v = 1; m_mis = 1; m_pc = tgt; m_instr = 32'h0000_0013; m_p4 = tgt + 32'd4;
      end
`else
      pc_exp = {tgt[31:2], 2'b00};
`endif
      if (rv && rdy) pend.push_back('{a, 1'b1});
    end else begin
      if (rv && rdy) begin
        pend.push_back('{a, 1'b0});
        pc_exp = pc_exp + 32'd4;
      end
      if (!st) begin
        m_mis = 0;
        if (fq.size() > 0) begin
          e = fq.pop_front();
          m_v = 1; m_pc = e.pc; m_instr = e.instr; m_p4 = e.pc + 32'd4;
        end else begin
          m_v = 0;
        end
      end
    end
    @(posedge clk); #1;
    chk("ifid_vld", 32'(if_id_valid), 32'(m_v));
    if (m_v) begin
      chk("ifid_pc", if_id_pc, m_pc);
      chk("ifid_instr", if_id_instr, m_instr);
      chk("ifid_pc4", if_id_pc_plus4, m_p4);
`ifdef IF_MISALIGN_TRAP_EN
      chk("ifid_misalign", 32'(if_id_misalign), 32'(m_mis));
`endif
    end
  endtask

  task automatic run_to_valid(input int mode, output int cyc);
    cyc = 0;
    do begin
      step(1'b0, 1'b0, 32'h0, 1'b1, mode);
      cyc++;
    end while (!if_id_valid && cyc < 12);
    if (!if_id_valid) chk("valid_timeout", 32'(if_id_valid), 1);
  endtask

  initial begin
    int cyc;
    logic st, rd, rdy;
    logic [31:0] tgt;
    #2;
    // Streaming from reset with single-cycle memory
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("first_vld", 32'(if_id_valid), 1);
    chk("first_pc", if_id_pc, RPC);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("second_pc", if_id_pc, RPC + 32'd4);
    chk("second_pc4", if_id_pc_plus4, RPC + 32'd8);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    // Memory not ready while 0x10 is requested
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1);
      chk("hold_addr", imem_addr, 32'h10);
    end
    chk("drain_bubble", 32'(if_id_valid), 0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("resume_pc", if_id_pc, 32'h10);

    // Stall holding 0x8
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("pre_stall_pc", if_id_pc, 32'h8);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1);
      chk("stall_hold_pc", if_id_pc, 32'h8);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("post_stall_pc0", if_id_pc, 32'hC);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("post_stall_pc1", if_id_pc, 32'h10);

    // Redirect with two fetches in flight
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 2);
    step(1'b0, 1'b0, 32'h0, 1'b1, 2);
    step(1'b0, 1'b1, 32'h100, 1'b1, 2);
    run_to_valid(1, cyc);
    chk("redir_pc", if_id_pc, 32'h100);
    chk("redir_latency", 32'(cyc), 3);

    // Redirect and stall together
    step(1'b1, 1'b1, 32'h200, 1'b1, 1);
    chk("rs_clear", 32'(if_id_valid), 0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("rs_bubble", 32'(if_id_valid), 0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("rs_vld", 32'(if_id_valid), 1);
    chk("rs_pc", if_id_pc, 32'h200);

    // PC wrap-around
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("wrap_pc0", if_id_pc, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("wrap_pc1", if_id_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("wrap_pc2", if_id_pc, 32'h0);

    // Misaligned redirect target
`ifdef IF_MISALIGN_TRAP_EN
    step(1'b0, 1'b1, 32'h102, 1'b1, 1);
    chk("mis_vld", 32'(if_id_valid), 1);
    chk("mis_flag", 32'(if_id_misalign), 1);
    chk("mis_pc", if_id_pc, 32'h102);
    chk("mis_instr", if_id_instr, 32'h0000_0013);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1);
      chk("mis_no_req", 32'(imem_req_valid), 0);
    end
    step(1'b0, 1'b1, 32'h300, 1'b1, 1);
    run_to_valid(1, cyc);
    chk("mis_resume_pc", if_id_pc, 32'h300);
`else
    step(1'b0, 1'b1, 32'h102, 1'b1, 1);
    run_to_valid(1, cyc);
    chk("align_force_pc", if_id_pc, 32'h100);
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(499) == 0) do_reset();
      st  = ($urandom_range(4) == 0);
      rd  = ($urandom_range(19) == 0);
      rdy = ($urandom_range(3) != 0);
      case ($urandom_range(7))
        0:       tgt = $urandom;
        1:       tgt = 32'hFFFF_FFF0;
        default: tgt = $urandom & 32'hFFFF_FFFC;
      endcase
      step(st, rd, tgt, rdy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
